// File: rtl/cnt3_seq_monitor_if.sv
// Bus between the JK down-counter / monitor (slave) and its consumer or
// stimulus side (master). The err_cnt signal only exists when the
// CNT3MON_ERRCNT_EN macro is defined.
interface cnt3_seq_monitor_if #(
    parameter int WIDTH = 3,
    parameter int WRAPW = 8
);
    logic             en;
    logic [WIDTH-1:0] count;
    logic             err_clr;
    logic             wrap_pulse;
    logic [WRAPW-1:0] wrap_cnt;
    logic             seq_err;
    logic             locked;
`ifdef CNT3MON_ERRCNT_EN
    logic [3:0]       err_cnt;
`endif

`ifdef CNT3MON_ERRCNT_EN
    modport master (
        output en, count, err_clr,
        input  wrap_pulse, wrap_cnt, seq_err, locked, err_cnt
    );
    modport slave (
        input  en, count, err_clr,
        output wrap_pulse, wrap_cnt, seq_err, locked, err_cnt
    );
`else
    modport master (
        output en, count, err_clr,
        input  wrap_pulse, wrap_cnt, seq_err, locked
    );
    modport slave (
        input  en, count, err_clr,
        output wrap_pulse, wrap_cnt, seq_err, locked
    );
`endif
endinterface

// File: rtl/cnt3_seq_monitor.sv
// Sequence monitor for the 3-bit JK down-counter. Checks that every enabled
// sample of count is the previous value minus one (mod 2^WIDTH), tolerating
// stalls, counts legal 0 -> max wraps and declares lock after 2^WIDTH
// consecutive legal steps.
// Optional: define CNT3MON_ERRCNT_EN to add the saturating err_cnt output.
//
// state  | meaning
// -------+-------------------------------------------------------------
// ACQ    | waiting for first enabled sample to seed prev, no checking
// TRACK  | checking steps, counting consecutive legal steps in good
// LOCKED | full clean cycle seen; any illegal step drops back to TRACK
module cnt3_seq_monitor #(
    parameter int WIDTH = 3,
    parameter int WRAPW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    cnt3_seq_monitor_if.slave      bus
);

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH:0]   GOOD_FULL = {1'b1, {WIDTH{1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH:0]   good_q, good_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic [WRAPW-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             seq_err_q, seq_err_d;
`ifdef CNT3MON_ERRCNT_EN
    logic [3:0]       err_cnt_q, err_cnt_d;
`endif

    logic [WIDTH-1:0] exp_val;
    logic             step_legal;
    logic             step_stall;
    logic             step_wrap;
    logic [WIDTH:0]   good_inc;

    // Classify the current sample against the expected decrement.
    always_comb begin
        exp_val    = prev_q - 1'b1;
        step_legal = (bus.count == exp_val);
        step_stall = (bus.count == prev_q);
        step_wrap  = step_legal && (prev_q == '0) && (bus.count == CNT_MAX);
        good_inc   = good_q + 1'b1;
    end

    // Next-state and next-datapath values; stalls fall through with everything held.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        good_d       = good_q;
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        // Clear first so an illegal step on the same edge overrides it.
        seq_err_d    = bus.err_clr ? 1'b0 : seq_err_q;
`ifdef CNT3MON_ERRCNT_EN
        err_cnt_d    = bus.err_clr ? 4'd0 : err_cnt_q;
`endif
        if (bus.en) begin
            case (state_q)
                ACQ: begin
                    prev_d  = bus.count;
                    good_d  = '0;
                    state_d = TRACK;
                end
                TRACK, LOCKED: begin
                    if (step_legal) begin
                        prev_d = bus.count;
                        if (state_q == TRACK) begin
                            good_d = good_inc;
                            if (good_inc == GOOD_FULL) begin
                                state_d = LOCKED;
                            end
                        end
                        if (step_wrap) begin
                            wrap_pulse_d = 1'b1;
                            wrap_cnt_d   = wrap_cnt_q + 1'b1;
                        end
                    end else if (!step_stall) begin
                        seq_err_d = 1'b1;
                        prev_d    = bus.count;
                        good_d    = '0;
                        state_d   = TRACK;
`ifdef CNT3MON_ERRCNT_EN
                        if (err_cnt_d != 4'hF) begin
                            err_cnt_d = err_cnt_d + 4'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_d = ACQ;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Tracking and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q       <= '0;
            good_q       <= '0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
            seq_err_q    <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            good_q       <= good_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
            seq_err_q    <= seq_err_d;
        end
    end

`ifdef CNT3MON_ERRCNT_EN
    // Saturating illegal-step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 4'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`endif

    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.wrap_cnt   = wrap_cnt_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.locked     = (state_q == LOCKED);

endmodule
